// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS control FSM driving the cpu_MIPS datapath control bundle
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       O,
  input  logic       mult_done,
  output logic [1:0] iord,
  output logic [1:0] excpControl,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [2:0] srcWrite,
  output logic [3:0] srcData,
  output logic [1:0] aluScrcA,
  output logic [1:0] aluScrcB,
  output logic [2:0] aluControl,
  output logic       aluOutControl,
  output logic [2:0] pcSource,
  output logic       pcWrite,
  output logic       epcControl,
  output logic       multControl
);
  typedef enum logic [4:0] {
    RESET, FETCH0, FETCH1, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM0, MEM1,
    WB_L, MEMW, BR, JMP, JAL, JR, LUI, MFHI, MFLO, RTE, MULT_START, MULT_WAIT,
    EXC_EPC, EXC_RD0, EXC_RD1, EXC_JMP
  } state_t;

  typedef struct packed {
    logic [1:0] iord;
    logic [1:0] excp;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [2:0] src_write;
    logic [3:0] src_data;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [2:0] alu_ctl;
    logic       alu_out;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc;
    logic       mult;
  } ctl_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  state_t     r_state, w_next;
  logic       r_run;
  logic       r_bne;
  logic [1:0] r_excp, w_next_excp;
  ctl_t       r_ctl;
  logic       w_br_take;

  function automatic ctl_t decode(input state_t s, input logic [5:0] f, input logic [1:0] e);
    ctl_t c;
    c = '0;
    case (s)
      RESET:      begin c.reg_write = 1'b1; c.src_write = 3'd3; c.src_data = 4'd6; end
      FETCH1:     begin c.ir_write = 1'b1; c.alu_b = 2'd1; c.alu_ctl = ALU_ADD; c.pc_write = 1'b1; end
      DECODE:     begin c.alu_b = 2'd3; c.alu_ctl = ALU_ADD; c.alu_out = 1'b1; end
      EXEC_R: begin
        c.alu_a   = 2'd1;
        c.alu_ctl = (f == 6'h22) ? ALU_SUB : (f == 6'h24) ? ALU_AND : ALU_ADD;
        c.alu_out = 1'b1;
      end
      WB_R:       begin c.reg_write = 1'b1; c.src_write = 3'd1; end
      EXEC_I, ADDR: begin c.alu_a = 2'd1; c.alu_b = 2'd2; c.alu_ctl = ALU_ADD; c.alu_out = 1'b1; end
      WB_I:       c.reg_write = 1'b1;
      MEM0, MEM1: c.iord = 2'd1;
      WB_L:       begin c.reg_write = 1'b1; c.src_data = 4'd1; end
      MEMW:       begin c.iord = 2'd1; c.mem_write = 1'b1; end
      BR:         begin c.alu_a = 2'd1; c.alu_ctl = ALU_SUB; c.pc_source = 3'd1; end
      JMP:        begin c.pc_source = 3'd2; c.pc_write = 1'b1; end
      JAL: begin
        c.reg_write = 1'b1; c.src_write = 3'd2; c.src_data = 4'd3;
        c.pc_source = 3'd2; c.pc_write = 1'b1;
      end
      JR:         begin c.alu_a = 2'd1; c.pc_write = 1'b1; end
      LUI:        begin c.reg_write = 1'b1; c.src_data = 4'd2; end
      MFHI:       begin c.reg_write = 1'b1; c.src_write = 3'd1; c.src_data = 4'd4; end
      MFLO:       begin c.reg_write = 1'b1; c.src_write = 3'd1; c.src_data = 4'd5; end
      RTE:        begin c.pc_source = 3'd4; c.pc_write = 1'b1; end
      MULT_START: c.mult = 1'b1;
      EXC_EPC:    begin c.alu_b = 2'd1; c.alu_ctl = ALU_SUB; c.epc = 1'b1; c.excp = e; end
      EXC_RD0, EXC_RD1: begin c.iord = 2'd2; c.excp = e; end
      EXC_JMP:    begin c.pc_source = 3'd3; c.pc_write = 1'b1; c.excp = e; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next      = r_state;
    w_next_excp = r_excp;
    case (r_state)
      RESET:  w_next = r_run ? FETCH0 : RESET;
      FETCH0: w_next = FETCH1;
      FETCH1: w_next = DECODE;
      DECODE: begin
        w_next      = EXC_EPC;
        w_next_excp = 2'd0;
        case (opcode)
          6'h00: case (funct)
                   6'h20, 6'h22, 6'h24: w_next = EXEC_R;
                   6'h08:               w_next = JR;
                   6'h10:               w_next = MFHI;
                   6'h12:               w_next = MFLO;
                   6'h18:               w_next = MULT_START;
                   default:             w_next = EXC_EPC;
                 endcase
          6'h08:        w_next = EXEC_I;
          6'h23, 6'h2b: w_next = ADDR;
          6'h04, 6'h05: w_next = BR;
          6'h02:        w_next = JMP;
          6'h03:        w_next = JAL;
          6'h0f:        w_next = LUI;
          6'h10:        w_next = (funct == 6'h13) ? RTE : EXC_EPC;
          default:      w_next = EXC_EPC;
        endcase
      end
      // Overflow diverts into the exception path before any writeback happens.
      EXEC_R: begin w_next = O ? EXC_EPC : WB_R; w_next_excp = O ? 2'd1 : r_excp; end
      EXEC_I: begin w_next = O ? EXC_EPC : WB_I; w_next_excp = O ? 2'd1 : r_excp; end
      ADDR:      w_next = (opcode == 6'h23) ? MEM0 : MEMW;
      MEM0:      w_next = MEM1;
      MEM1:      w_next = WB_L;
      MULT_START: w_next = MULT_WAIT;
      MULT_WAIT: w_next = mult_done ? FETCH0 : MULT_WAIT;
      EXC_EPC:   w_next = EXC_RD0;
      EXC_RD0:   w_next = EXC_RD1;
      EXC_RD1:   w_next = EXC_JMP;
      default:   w_next = FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET;
      r_run   <= 1'b0;
      r_bne   <= 1'b0;
      r_excp  <= 2'd0;
      r_ctl   <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      r_excp  <= w_next_excp;
      r_ctl   <= decode(w_next, funct, w_next_excp);
      if (r_state == DECODE) r_bne <= (opcode == 6'h05);
    end
  end

  // The branch decision uses the flag from the compare happening in BR itself.
  assign w_br_take = (r_state == BR) && (zero ^ r_bne);

  assign iord          = r_ctl.iord;
  assign excpControl   = r_ctl.excp;
  assign memWrite      = r_ctl.mem_write;
  assign irWrite       = r_ctl.ir_write;
  assign regWrite      = r_ctl.reg_write;
  assign srcWrite      = r_ctl.src_write;
  assign srcData       = r_ctl.src_data;
  assign aluScrcA      = r_ctl.alu_a;
  assign aluScrcB      = r_ctl.alu_b;
  assign aluControl    = r_ctl.alu_ctl;
  assign aluOutControl = r_ctl.alu_out;
  assign pcSource      = r_ctl.pc_source;
  assign pcWrite       = r_ctl.pc_write | w_br_take;
  assign epcControl    = r_ctl.epc;
  assign multControl   = r_ctl.mult;
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit, one expected control word per cycle
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, O, mult_done;
  logic [1:0] iord, excpControl, aluScrcA, aluScrcB;
  logic       memWrite, irWrite, regWrite, aluOutControl, pcWrite, epcControl, multControl;
  logic [2:0] srcWrite, aluControl, pcSource;
  logic [3:0] srcData;

  typedef struct packed {
    logic [1:0] iord;
    logic [1:0] excp;
    logic       mw, irw, rw;
    logic [2:0] sw;
    logic [3:0] sd;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic       ao;
    logic [2:0] ps;
    logic       pw, epc, mc;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  v;
    ctl_t  m;
  } sb_t;

  sb_t  sb[$];
  ctl_t obs;
  ctl_t full;
  int   n_checks = 0;
  int   n_errors = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .O(O),
    .mult_done(mult_done), .iord(iord), .excpControl(excpControl), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite), .srcWrite(srcWrite), .srcData(srcData),
    .aluScrcA(aluScrcA), .aluScrcB(aluScrcB), .aluControl(aluControl),
    .aluOutControl(aluOutControl), .pcSource(pcSource), .pcWrite(pcWrite),
    .epcControl(epcControl), .multControl(multControl)
  );

  always #5 clk = ~clk;

  assign obs = {iord, excpControl, memWrite, irWrite, regWrite, srcWrite, srcData, aluScrcA,
                aluScrcB, aluControl, aluOutControl, pcSource, pcWrite, epcControl, multControl};

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t ent;
      ent = sb.pop_front();
      check(ent.tag, obs & ent.m, ent.v & ent.m);
    end
  end

  task automatic cyc(input string tag, input ctl_t v, input ctl_t m);
    sb.push_back('{tag, v, m});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    ctl_t e;
    opcode = op;
    funct  = fn;
    e = '0;                                           cyc("fetch0", e, full);
    e.irw = 1'b1; e.b = 2'd1; e.alu = 3'b001; e.pw = 1'b1; cyc("fetch1", e, full);
    e = '0; e.b = 2'd3; e.alu = 3'b001; e.ao = 1'b1;  cyc("decode", e, full);
  endtask

  task automatic exc_tail(input logic [1:0] code);
    ctl_t e;
    e = '0; e.b = 2'd1; e.alu = 3'b010; e.epc = 1'b1; e.excp = code; cyc("exc_epc", e, full);
    e = '0; e.iord = 2'd2; e.excp = code;                           cyc("exc_rd0", e, full);
    cyc("exc_rd1", e, full);
    e = '0; e.ps = 3'd3; e.pw = 1'b1; e.excp = code;                cyc("exc_jmp", e, full);
  endtask

  task automatic r_alu(input logic [5:0] fn, input logic [2:0] op, input logic ovf);
    ctl_t e;
    O = ovf;
    fetch(6'h00, fn);
    e = '0; e.a = 2'd1; e.alu = op; e.ao = 1'b1; cyc("exec_r", e, full);
    if (ovf) exc_tail(2'd1);
    else begin
      e = '0; e.rw = 1'b1; e.sw = 3'd1; cyc("wb_r", e, full);
    end
    O = 1'b0;
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic take);
    ctl_t e;
    zero = z;
    fetch(op, 6'h00);
    e = '0; e.a = 2'd1; e.alu = 3'b010; e.ps = 3'd1; e.pw = take; cyc("br", e, full);
    zero = 1'b0;
  endtask

  task automatic one_state(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input ctl_t e);
    fetch(op, fn);
    cyc(tag, e, full);
  endtask

  initial begin
    ctl_t e, m;
    full = '1;
    reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; O = 1'b0; mult_done = 1'b0;
    @(posedge clk);
    #1;
    e = '0;
    cyc("in_reset", e, full);
    reset = 1'b1;
    cyc("release", e, full);
    e.rw = 1'b1; e.sw = 3'd3; e.sd = 4'd6; cyc("reset_state", e, full);

    r_alu(6'h20, 3'b001, 1'b0);
    r_alu(6'h22, 3'b010, 1'b0);
    r_alu(6'h24, 3'b011, 1'b0);
    r_alu(6'h20, 3'b001, 1'b1);

    O = 1'b0;
    fetch(6'h08, 6'h00);
    e = '0; e.b = 2'd2; e.alu = 3'b001; e.ao = 1'b1;
    m = '0; m.b = '1; m.alu = '1; m.ao = 1'b1; m.rw = 1'b1; m.mw = 1'b1; m.pw = 1'b1;
    cyc("exec_i", e, m);
    e = '0; e.rw = 1'b1; cyc("wb_i", e, full);
    O = 1'b1;
    fetch(6'h08, 6'h00);
    e = '0; e.b = 2'd2; e.alu = 3'b001; e.ao = 1'b1; cyc("exec_i_ovf", e, m);
    exc_tail(2'd1);
    O = 1'b0;

    m = '0; m.mw = 1'b1; m.rw = 1'b1; m.pw = 1'b1; m.irw = 1'b1; m.ao = 1'b1;
    fetch(6'h23, 6'h00);
    e = '0; e.ao = 1'b1; cyc("lw_addr", e, m);
    e = '0; e.iord = 2'd1; cyc("mem0", e, full);
    cyc("mem1", e, full);
    e = '0; e.rw = 1'b1; e.sd = 4'd1; cyc("wb_l", e, full);
    fetch(6'h2b, 6'h00);
    e = '0; e.ao = 1'b1; cyc("sw_addr", e, m);
    e = '0; e.iord = 2'd1; e.mw = 1'b1; cyc("memw", e, full);

    branch(6'h04, 1'b1, 1'b1);
    branch(6'h04, 1'b0, 1'b0);
    branch(6'h05, 1'b1, 1'b0);
    branch(6'h05, 1'b0, 1'b1);

    e = '0; e.ps = 3'd2; e.pw = 1'b1; one_state("jmp", 6'h02, 6'h00, e);
    e.rw = 1'b1; e.sw = 3'd2; e.sd = 4'd3; one_state("jal", 6'h03, 6'h00, e);
    e = '0; e.a = 2'd1; e.pw = 1'b1; one_state("jr", 6'h00, 6'h08, e);
    e = '0; e.rw = 1'b1; e.sd = 4'd2; one_state("lui", 6'h0f, 6'h00, e);
    e = '0; e.ps = 3'd4; e.pw = 1'b1; one_state("rte", 6'h10, 6'h13, e);
    e = '0; e.rw = 1'b1; e.sw = 3'd1; e.sd = 4'd4; one_state("mfhi", 6'h00, 6'h10, e);

    e = '0; e.mc = 1'b1; one_state("mult_start", 6'h00, 6'h18, e);
    e = '0;
    for (int i = 0; i < 10; i++) cyc("mult_wait", e, full);
    mult_done = 1'b1;
    cyc("mult_wait_done", e, full);
    mult_done = 1'b0;
    fetch(6'h00, 6'h18);
    e = '0; e.mc = 1'b1; cyc("mult_start2", e, full);
    mult_done = 1'b1;
    e = '0; cyc("mult_wait_fast", e, full);
    mult_done = 1'b0;
    fetch(6'h3f, 6'h00);
    exc_tail(2'd0);

    fetch(6'h3f, 6'h00);
    e = '0; e.b = 2'd1; e.alu = 3'b010; e.epc = 1'b1; cyc("bad_epc", e, full);
    e = '0; e.iord = 2'd2; cyc("bad_rd0", e, full);
    reset = 1'b0;
    e = '0;
    cyc("abort0", e, full);
    cyc("abort1", e, full);
    reset = 1'b1;
    cyc("abort_release", e, full);
    e.rw = 1'b1; e.sw = 3'd3; e.sd = 4'd6; cyc("reset_again", e, full);
    fetch(6'h02, 6'h00);
    e = '0; e.ps = 3'd2; e.pw = 1'b1; cyc("jmp_after_reset", e, full);
    e = '0; cyc("final_fetch0", e, full);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
